// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - control/handshake bundle between the sequencer and its datapath/memories
interface multicycle_sequencer_if;
   logic        run;
   logic [18:0] instr;
   logic        zero_flag;
   logic        carry_flag;
   logic        imem_ack;
   logic        dmem_ack;
   logic        imem_req;
   logic        dmem_req;
   logic        dmem_we;
   logic        ir_load;
   logic        pc_inc;
   logic        pc_load;
   logic        reg_write;
   logic [1:0]  select_to_write;
   logic        select_r2;
   logic        select_alu_arg;
   logic [2:0]  alu_function;
   logic [1:0]  sh_ro_function;
   logic        enable_zero;
   logic        enable_carry;
   logic        instr_retired;
   logic        error;

   modport master (
      input  run, instr, zero_flag, carry_flag, imem_ack, dmem_ack,
      output imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, reg_write,
             select_to_write, select_r2, select_alu_arg, alu_function, sh_ro_function,
             enable_zero, enable_carry, instr_retired, error
   );

   modport slave (
      output run, instr, zero_flag, carry_flag, imem_ack, dmem_ack,
      input  imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, reg_write,
             select_to_write, select_r2, select_alu_arg, alu_function, sh_ro_function,
             enable_zero, enable_carry, instr_retired, error
   );
endinterface

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory watchdog
module multicycle_sequencer #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   multicycle_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_SHIFT, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_ILLEGAL
   } iclass_t;

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   iclass_t          iclass;
   logic [4:0]       op;
   logic             taken;
   logic             unused_instr;

   assign op           = bus.instr[18:14];
   assign unused_instr = ^bus.instr[13:0];

   always_comb begin
      iclass = C_ILLEGAL;
      if (!op[4])                 iclass = C_ALU;
      else if (op[4:2] == 3'b110) iclass = C_SHIFT;
      else if (op == 5'b10000)    iclass = C_LOAD;
      else if (op == 5'b10001)    iclass = C_STORE;
      else if (op[4:2] == 3'b101) iclass = C_BRANCH;
      else if (op == 5'b11100)    iclass = C_JUMP;
   end

   always_comb begin
      case (op[1:0])
         2'b00:   taken = bus.zero_flag;
         2'b01:   taken = !bus.zero_flag;
         2'b10:   taken = bus.carry_flag;
         default: taken = !bus.carry_flag;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The wait counter only survives while a request is pending, so every entry to FETCH/MEM sees zero.
   always_comb begin
      state_d             = state_q;
      cnt_d               = '0;
      bus.imem_req        = 1'b0;
      bus.dmem_req        = 1'b0;
      bus.dmem_we         = 1'b0;
      bus.ir_load         = 1'b0;
      bus.pc_inc          = 1'b0;
      bus.pc_load         = 1'b0;
      bus.reg_write       = 1'b0;
      bus.select_to_write = 2'b00;
      bus.select_r2       = 1'b0;
      bus.select_alu_arg  = 1'b0;
      bus.alu_function    = 3'b000;
      bus.sh_ro_function  = 2'b00;
      bus.enable_zero     = 1'b0;
      bus.enable_carry    = 1'b0;
      bus.instr_retired   = 1'b0;
      bus.error           = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.run) state_d = S_FETCH;
         end
         S_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ack) begin
               bus.ir_load = 1'b1;
               bus.pc_inc  = 1'b1;
               state_d     = S_DECODE;
            end else if (cnt_q == TIMEOUT_CNT) begin
               state_d = S_ERROR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d           = bus.run ? S_FETCH : S_IDLE;
            bus.instr_retired = 1'b1;
            case (iclass)
               C_ALU: begin
                  bus.alu_function   = bus.instr[16:14];
                  bus.select_alu_arg = ~bus.instr[17];
                  bus.select_r2      = 1'b1;
                  bus.reg_write      = 1'b1;
                  bus.enable_zero    = 1'b1;
                  bus.enable_carry   = 1'b1;
               end
               C_SHIFT: begin
                  bus.sh_ro_function  = bus.instr[15:14];
                  bus.select_to_write = 2'b01;
                  bus.reg_write       = 1'b1;
               end
               C_BRANCH: bus.pc_load = taken;
               C_JUMP:   bus.pc_load = 1'b1;
               C_LOAD, C_STORE: begin
                  bus.instr_retired = 1'b0;
                  state_d           = S_MEM;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            bus.dmem_req = 1'b1;
            bus.dmem_we  = (iclass == C_STORE);
            if (bus.dmem_ack) begin
               if (iclass == C_STORE) begin
                  bus.instr_retired = 1'b1;
                  state_d           = bus.run ? S_FETCH : S_IDLE;
               end else begin
                  state_d = S_WB;
               end
            end else if (cnt_q == TIMEOUT_CNT) begin
               state_d = S_ERROR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WB: begin
            bus.select_to_write = 2'b10;
            bus.reg_write       = 1'b1;
            bus.instr_retired   = 1'b1;
            state_d             = bus.run ? S_FETCH : S_IDLE;
         end
         S_ERROR: begin
            bus.error = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the 19-bit-instruction processor datapath. Replaces single-cycle decoding with an explicit sequence: FETCH, DECODE, EXEC, MEM, WB.
- Drives PC, IR, register-file, ALU, shifter and data-memory controls.
- Handshakes with instruction memory and data memory.
- Runs a per-access timeout watchdog.

Parameters:
- TIMEOUT, 15: maximum wait cycles for a memory ack before entering ERROR (1..255).
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- run  input  1  enables instruction execution
- instr  input  19  current IR contents
- zero_flag  input  1  datapath zero flag
- carry_flag  input  1  datapath carry flag
- imem_ack  input  1  instruction memory data valid
- dmem_ack  input  1  data memory access complete
- imem_req  output  1  instruction fetch request
- dmem_req  output  1  data memory request
- dmem_we  output  1  data memory write (store)
- ir_load  output  1  load IR from instruction memory
- pc_inc  output  1  PC <= PC+1
- pc_load  output  1  PC <= branch/jump target
- reg_write  output  1  register file write enable
- select_to_write  output  2  00 ALU, 01 shift/rotate, 10 data memory
- select_r2  output  1  1: R2 from instr[7:5]; 0: from instr[13:11]
- select_alu_arg  output  1  1: register operand; 0: immediate
- alu_function  output  3  ALU op
- sh_ro_function  output  2  shift/rotate op
- enable_zero  output  1  zero flag update enable
- enable_carry  output  1  carry flag update enable
- instr_retired  output  1  one-cycle pulse per completed instruction
- error  output  1  watchdog tripped; sticky

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERROR. State is registered.
- Outputs are decoded combinationally from state and instr. Any output not listed for the current state is 0.
- On reset: state=IDLE, wait counter=0, all outputs 0. Reset asserted in any state, mid-access included, aborts the access immediately.
- Instruction classes by instr[18:14]:
  - ALU: [18:17]=00 (register) or 01 (immediate).
  - SHIFT: [18:16]=110.
  - LOAD: 10000.
  - STORE: 10001.
  - BRANCH: [18:16]=101, cond [15:14]: 00 Z, 01 !Z, 10 C, 11 !C.
  - JUMP: 11100.
  - Everything else is ILLEGAL.
- IDLE: if run=1, go to FETCH.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_load=1 and pc_inc=1 in the same cycle, then go to DECODE.
- DECODE: one cycle, no strobes; go to EXEC.
- EXEC:
  - ALU: alu_function=instr[16:14], select_alu_arg=~instr[17], select_r2=1, select_to_write=00, reg_write=1, enable_zero=1, enable_carry=1, instr_retired=1.
  - SHIFT: sh_ro_function=instr[15:14], select_to_write=01, reg_write=1, instr_retired=1. Flags are not updated.
  - BRANCH: pc_load=1 only if the condition is true; instr_retired=1.
  - JUMP: pc_load=1, instr_retired=1.
  - LOAD/STORE: go to MEM.
  - ILLEGAL: instr_retired=1, no other strobes (treated as a NOP).
- MEM:
  - dmem_req=1.
  - For STORE: dmem_we=1 and select_r2=0.
  - On dmem_ack: LOAD goes to WB; STORE asserts instr_retired and ends the instruction.
- WB: select_to_write=10, reg_write=1, instr_retired=1; ends the instruction.
- End of instruction: go to FETCH if run=1, else IDLE. run is sampled only there; deasserting it mid-instruction completes the current instruction.
- Latency with ack in the first request cycle:
  - ALU, SHIFT, BRANCH, JUMP, ILLEGAL: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Watchdog:
  - The wait counter clears on entry to FETCH and to MEM, and increments each cycle the request is held without ack.
  - If an ack arrives in the same cycle the counter equals TIMEOUT, the ack wins.
  - If the counter reaches TIMEOUT with no ack, go to ERROR.
- ERROR: error=1, all other outputs 0. Only reset exits this state.
- Acks arriving outside their request state are ignored.

Test Plan:
- Reset mid-FETCH with imem_req=1 → next cycle state IDLE, all outputs 0; run=1 → imem_req=1 one cycle later.
- ALU immediate 01_011_xxxx, imem_ack immediate → reg_write=1, alu_function=011, select_alu_arg=0, enable_zero=enable_carry=1 in cycle 3; instr_retired pulse in the same cycle.
- LOAD 10000, dmem_ack delayed 4 cycles → dmem_req held 5 cycles, dmem_we=0, then WB: select_to_write=10, reg_write=1; total 9 cycles.
- STORE 10001 → in MEM, dmem_we=1 and select_r2=0; no reg_write at any point in the instruction.
- BRANCH 10101 (!Z) with zero_flag=1 → pc_load=0; with zero_flag=0 → pc_load=1 in EXEC.
- imem_ack never asserted, TIMEOUT=15 → ERROR after 16 FETCH cycles, error stays 1 with run toggling until reset. Separately, ack in exactly the TIMEOUT cycle → normal DECODE.
